// File: rtl/reorder_buffer_mw.sv
// Multi-port reorder buffer: in-order allocation at dispatch, out-of-order CDB completion,
// and in-order retirement of up to RETIRE_WIDTH entries per cycle.
module reorder_buffer_mw #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TAG_WIDTH    = 5,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned REG_WIDTH    = 5,
    parameter int unsigned COMMIT_PORTS = 2,
    parameter int unsigned RETIRE_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               dispatch_valid,
    input  logic [REG_WIDTH-1:0]               dispatch_rd,
    input  logic                               dispatch_regwr,
    output logic                               dispatch_ready,
    output logic [TAG_WIDTH-1:0]               dispatch_tag,
    input  logic [COMMIT_PORTS-1:0]            cdb_valid,
    input  logic [COMMIT_PORTS*TAG_WIDTH-1:0]  cdb_tag,
    input  logic [COMMIT_PORTS*DATA_WIDTH-1:0] cdb_value,
    input  logic                               flush,
    input  logic [TAG_WIDTH-1:0]               lookup_tag,
    output logic                               lookup_hit,
    output logic [DATA_WIDTH-1:0]              lookup_value,
    output logic [RETIRE_WIDTH-1:0]            retire_valid,
    output logic [RETIRE_WIDTH-1:0]            retire_regwr,
    output logic [RETIRE_WIDTH*REG_WIDTH-1:0]  retire_rd,
    output logic [RETIRE_WIDTH*DATA_WIDTH-1:0] retire_value,
    output logic [RETIRE_WIDTH*TAG_WIDTH-1:0]  retire_tag,
    output logic [TAG_WIDTH-1:0]               count,
    output logic                               full,
    output logic                               empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      ready_q;
    logic [DEPTH-1:0]      regwr_q;
    logic [REG_WIDTH-1:0]  rd_q    [DEPTH];
    logic [DATA_WIDTH-1:0] value_q [DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [TAG_WIDTH-1:0]  count_q;

    logic                  accept;
    logic [DEPTH-1:0]      cdb_we;
    logic [DATA_WIDTH-1:0] cdb_wv  [DEPTH];
    logic [RETIRE_WIDTH-1:0] ret_ok;
    logic [PTR_W-1:0]      ret_idx [RETIRE_WIDTH];
    logic [TAG_WIDTH-1:0]  ret_n;
    logic [PTR_W-1:0]      head_next;
    logic [PTR_W-1:0]      tail_next;
    logic [PTR_W-1:0]      lookup_idx;
    logic                  lookup_in_range;

    // Status derived straight from the registered pointers
    always_comb begin
        full           = (count_q == TAG_WIDTH'(DEPTH));
        empty          = (count_q == '0);
        count          = count_q;
        dispatch_ready = !full;
        dispatch_tag   = TAG_WIDTH'(tail_q) + TAG_WIDTH'(1);
        accept         = dispatch_valid && !full && !flush;
        tail_next      = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
    end

    // CDB write enables per entry; scanning ports high to low lets the lowest index win
    always_comb begin
        cdb_we = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            cdb_wv[k] = '0;
            for (int i = int'(COMMIT_PORTS) - 1; i >= 0; i--) begin
                if (cdb_valid[i] && valid_q[k] &&
                    cdb_tag[i*TAG_WIDTH +: TAG_WIDTH] == TAG_WIDTH'(k + 1)) begin
                    cdb_we[k] = 1'b1;
                    cdb_wv[k] = cdb_value[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Longest ready run from head, capped at RETIRE_WIDTH and at the occupancy
    always_comb begin
        logic run;
        run    = 1'b1;
        ret_ok = '0;
        ret_n  = '0;
        for (int j = 0; j < int'(RETIRE_WIDTH); j++) begin
            ret_idx[j] = PTR_W'((int'(head_q) + j) % int'(DEPTH));
            if (run && (j < int'(count_q)) && valid_q[ret_idx[j]] && ready_q[ret_idx[j]]) begin
                ret_ok[j] = 1'b1;
                ret_n     = ret_n + TAG_WIDTH'(1);
            end else begin
                run = 1'b0;
            end
        end
        head_next = PTR_W'((int'(head_q) + int'(ret_n)) % int'(DEPTH));
    end

    // Operand bypass query against pre-edge state
    always_comb begin
        lookup_in_range = (lookup_tag != '0) && (lookup_tag <= TAG_WIDTH'(DEPTH));
        lookup_idx      = PTR_W'(lookup_tag - TAG_WIDTH'(1));
        lookup_hit      = 1'b0;
        lookup_value    = '0;
        if (lookup_in_range && valid_q[lookup_idx] && ready_q[lookup_idx]) begin
            lookup_hit   = 1'b1;
            lookup_value = value_q[lookup_idx];
        end
    end

    // Control state and registered retire outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            ready_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            retire_valid <= '0;
            retire_regwr <= '0;
            retire_rd    <= '0;
            retire_value <= '0;
            retire_tag   <= '0;
        end else if (flush) begin
            valid_q      <= '0;
            ready_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            retire_valid <= '0;
            retire_regwr <= '0;
            retire_rd    <= '0;
            retire_value <= '0;
            retire_tag   <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (cdb_we[k]) ready_q[k] <= 1'b1;
            end
            for (int j = 0; j < int'(RETIRE_WIDTH); j++) begin
                retire_valid[j] <= ret_ok[j];
                if (ret_ok[j]) begin
                    valid_q[ret_idx[j]] <= 1'b0;
                    ready_q[ret_idx[j]] <= 1'b0;
                    retire_regwr[j]                          <= regwr_q[ret_idx[j]];
                    retire_rd[j*REG_WIDTH +: REG_WIDTH]      <= rd_q[ret_idx[j]];
                    retire_value[j*DATA_WIDTH +: DATA_WIDTH] <= value_q[ret_idx[j]];
                    retire_tag[j*TAG_WIDTH +: TAG_WIDTH]     <= TAG_WIDTH'(ret_idx[j]) + TAG_WIDTH'(1);
                end else begin
                    retire_regwr[j]                          <= 1'b0;
                    retire_rd[j*REG_WIDTH +: REG_WIDTH]      <= '0;
                    retire_value[j*DATA_WIDTH +: DATA_WIDTH] <= '0;
                    retire_tag[j*TAG_WIDTH +: TAG_WIDTH]     <= '0;
                end
            end
            if (accept) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                tail_q          <= tail_next;
            end
            head_q  <= head_next;
            count_q <= count_q + (accept ? TAG_WIDTH'(1) : TAG_WIDTH'(0)) - ret_n;
        end
    end

    // Entry payload; only meaningful while the valid bit is set
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (cdb_we[k]) value_q[k] <= cdb_wv[k];
            end
            if (accept) begin
                regwr_q[tail_q] <= dispatch_regwr;
                rd_q[tail_q]    <= dispatch_rd;
                value_q[tail_q] <= '0;
            end
        end
    end

endmodule

// File: doc/reorder_buffer_mw.md
Name: reorder_buffer_mw

Overview:
- Parametrised multi-port reorder buffer for the out-of-order core.
- Replaces the ROB array and head/tail/count logic that is currently hand-coded in top.
- Allocates one entry per cycle at dispatch and returns 1-based tags; tag 0 means "no tag".
- Accepts COMMIT_PORTS CDB completions per cycle and retires up to RETIRE_WIDTH ready entries per cycle, in program order, toward the register file; supports a full pipeline flush.

Parameters:
- DEPTH, 16: number of entries, any value ≥2 (need not be a power of two).
- TAG_WIDTH, 5: tag width; must satisfy 2^TAG_WIDTH > DEPTH.
- DATA_WIDTH, 64: width of the result value.
- REG_WIDTH, 5: width of the architectural register index.
- COMMIT_PORTS, 2: number of CDB write ports.
- RETIRE_WIDTH, 2: maximum entries retired per cycle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dispatch_valid  in  1  request to allocate an entry.
- dispatch_rd  in  REG_WIDTH  destination register.
- dispatch_regwr  in  1  instruction writes rd.
- dispatch_ready  out  1  equals !full; allocation accepted this edge.
- dispatch_tag  out  TAG_WIDTH  tag that will be given to the next allocation (tail+1).
- cdb_valid  in  COMMIT_PORTS  per-port completion strobe.
- cdb_tag  in  COMMIT_PORTS*TAG_WIDTH  packed tags; port i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- cdb_value  in  COMMIT_PORTS*DATA_WIDTH  packed results.
- flush  in  1  synchronous discard of all entries.
- lookup_tag  in  TAG_WIDTH  operand-bypass query.
- lookup_hit  out  1  queried entry is valid and ready.
- lookup_value  out  DATA_WIDTH  value of the queried entry.
- retire_valid  out  RETIRE_WIDTH  per-slot retire strobe; slot 0 is the oldest.
- retire_regwr  out  RETIRE_WIDTH  per-slot register-write enable.
- retire_rd  out  RETIRE_WIDTH*REG_WIDTH  per-slot destination register.
- retire_value  out  RETIRE_WIDTH*DATA_WIDTH  per-slot result.
- retire_tag  out  RETIRE_WIDTH*TAG_WIDTH  per-slot tag.
- count  out  TAG_WIDTH  number of occupied entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Entry state: valid, ready, regwr, rd, value. Pointers head and tail range 0..DEPTH-1 and wrap explicitly (DEPTH-1 → 0). The tag of entry k is k+1.
- Reset (async) and flush (sync) both do the following:
  - clear all valid bits;
  - set head=tail=count=0;
  - force all retire_* outputs to 0;
  - resulting outputs: dispatch_tag=1, empty=1, full=0.
- Flush takes priority over dispatch, CDB and retire in the same cycle; nothing is allocated, written or retired on that edge.
- Dispatch:
  - Accepted on an edge where dispatch_valid && !full, with full evaluated from the pre-edge count.
  - Writes entry[tail] with valid=1, ready=0, rd, regwr, value=0, then advances tail.
  - Retirement in the same cycle does not unblock a full ROB; a full ROB accepts nothing until count drops.
- CDB write, per port i with cdb_valid[i]:
  - If the tag is 1..DEPTH and entry[tag-1] is valid, set ready=1 and value=cdb_value[i].
  - Tag 0, an out-of-range tag, or a tag pointing at an invalid entry is ignored.
  - Two ports carrying the same tag: the lowest port index wins.
- Retire:
  - On each edge, take the longest run of valid&&ready entries starting at head, at most RETIRE_WIDTH long, stopping at the first non-ready entry (run may wrap past DEPTH-1).
  - Those entries are registered onto retire slots 0..n-1; higher slots get retire_valid=0.
  - Retired entries are invalidated and head advances by n. Latency: retire outputs are visible for one cycle following the edge.
  - Retire evaluates pre-edge state, so an entry completed by the CDB on edge t retires at the earliest on edge t+1.
- Count update: count_next = count + accepted − n. Dispatch and retire on the same edge are both applied.
- Lookup (combinational, pre-edge state):
  - lookup_hit = tag in 1..DEPTH && valid && ready; lookup_value = value when hit, else 0.
  - There is no CDB forwarding; the dispatcher snoops the CDB itself.
- dispatch_tag, count, full and empty are combinational from the registered pointers.

Test Plan:
- Reset, then dispatch 3 entries (rd 5,6,7; regwr=1) → dispatch_tag sequence 1,2,3; count=3; empty=0.
- CDB writes tag 2 (value 0xAA) then tag 1 (0x55) on the next cycle → the edge after the tag-1 write retires slot0 = tag1/rd5/0x55 and slot1 = tag2/rd6/0xAA; count=1.
- Fill all 16 entries, then assert dispatch_valid → full=1, dispatch_ready=0, no allocation. Retire one entry → next dispatch gets tag 1 (wrap-around).
- Complete tags 3,4,5 with head at tag 3, RETIRE_WIDTH=2 → tags 3,4 retire on one edge and tag 5 on the next.
- Both CDB ports carry tag 4 with values 0x1 and 0x2 → lookup_tag=4 gives lookup_hit=1, lookup_value=0x1.
- Assert flush with dispatch_valid=1 and a CDB write pending → count=0, dispatch_tag=1, no retire strobes. Assert async reset mid-cycle → outputs cleared immediately, without waiting for clk.
